rpn_stack_ctrl: RTL
===================

Name: rpn_stack_ctrl

Overview:
Command sequencer for the calculator's stack RAM. It accepts one command at a time: push, pop, dup, clear, or a binary arithmetic op. It drives the single-port RAM address, write-enable and write-data lines, and owns the stack pointer. It caches the top-of-stack value in a register so the display and LED logic can read it without a RAM access.

Parameters:
WIDTH, 8, data word width (RAM word and operands)
ADDR_W, 5, RAM address width; stack capacity DEPTH = 2**ADDR_W entries

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request; sampled only when cmd_ready=1
cmd  in  3  opcode: 000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 MUL, 110 DUP, 111 CLEAR
cmd_data  in  WIDTH  operand for PUSH (switch value)
cmd_ready  out  1  high only in S_IDLE
done  out  1  one-cycle pulse at command completion, including error completion
err_overflow  out  1  valid with done; PUSH or DUP rejected because stack full
err_underflow  out  1  valid with done; too few entries for the op
err_illegal  out  1  valid with done; opcode not supported in this build
tos  out  WIDTH  cached top-of-stack; 0 when empty
depth  out  ADDR_W+1  number of entries, 0..DEPTH
mem_addr  out  ADDR_W  RAM address
mem_wr  out  1  RAM write enable
mem_wdata  out  WIDTH  RAM write data
mem_rdata  in  WIDTH  RAM read data, valid one cycle after mem_addr is presented (registered-read RAM)

Behaviour:
- Reset, synchronous and active-high. The state goes to S_IDLE and all of the following are 0: depth, tos, done, all err_*, mem_wr, mem_addr, mem_wdata. RAM contents are untouched. Reset mid-command aborts the command with no done pulse.
- Accept: a command is accepted on a cycle T where the state is S_IDLE and cmd_valid=1. cmd and cmd_data are latched at T. cmd_ready is 0 from T+1 until the state returns to S_IDLE. NOP completes at T+1 with done and no state change.
- States: S_IDLE, S_WRITE, S_READ, S_EXEC, S_DONE.
- PUSH: T+1 is S_WRITE with mem_addr=depth, mem_wdata=cmd_data, mem_wr=1. At T+1: depth+=1, tos<=cmd_data, done=1.
- DUP: same as PUSH but writes tos instead of cmd_data.
- POP: T+1 is S_READ with mem_addr=depth-2. T+2 is S_DONE: depth-=1, done=1. tos<=mem_rdata, or tos<=0 if the new depth is 0 (in that case the read is don't-care).
- Binary op: a = tos, b = entry at depth-2. T+1 is S_READ with mem_addr=depth-2. T+2 is S_EXEC: r = b op a, mem_addr=depth-2, mem_wdata=r, mem_wr=1, tos<=r, depth-=1, done=1.
- Arithmetic is modulo 2**WIDTH: ADD b+a, SUB b-a, MUL is the low WIDTH bits of b*a.
- CLEAR: T+1 sets depth<=0, tos<=0, done=1. There is no RAM access.
- Error checks are evaluated at accept time:
  - PUSH or DUP with depth==DEPTH → err_overflow.
  - POP with depth==0 → err_underflow.
  - DUP with depth==0 → err_underflow.
  - Binary op with depth<2 → err_underflow.
  - On error: S_DONE at T+1 with done=1 and the flag set. depth, tos and RAM are unchanged, and mem_wr stays 0.
- mem_wr is high for exactly one cycle per successful PUSH, DUP or binary op, and is 0 in every other cycle.
- done and err_* are 0 in every cycle where done is not asserted.
- cmd_valid is ignored while cmd_ready=0; there is no queueing.
- Boundaries: PUSH at depth=DEPTH-1 succeeds and depth becomes DEPTH. A binary op at depth=2 leaves depth=1 with tos=r.

Optional Feature:
RPN_MUL_EN. When defined, opcode 101 performs MUL as described and synthesises a WIDTH×WIDTH multiplier. When undefined, opcode 101 completes at T+1 with done=1, err_illegal=1 and no state change; no multiplier is instantiated.

Test Plan:
- Reset, then PUSH 5, PUSH 3, ADD → done at T+2 of ADD, tos=8, depth=1, RAM[0]=8.
- PUSH 3, PUSH 10, SUB → tos=0xF9 (3-10 mod 256), depth=1. Then PUSH 200, PUSH 100, ADD → tos=44 (wrap).
- POP on an empty stack → done with err_underflow=1, depth=0, tos=0, mem_wr never high. ADD with depth=1 → err_underflow, tos unchanged.
- With ADDR_W=2: PUSH 1..4 → depth=4. A 5th PUSH → err_overflow, tos=4. DUP → err_overflow. POP → tos=3, depth=3.
- PUSH 7, PUSH 6, MUL → tos=42 with RPN_MUL_EN defined. Without it → err_illegal=1, depth=2, tos=6.
- Assert reset during S_READ of a POP → next cycle depth=0, tos=0, no done pulse. cmd_valid held high while busy is not re-accepted.

Source files
------------

// File: rtl/rpn_stack_ctrl_if.sv
// rpn_stack_ctrl_if: command handshake, status and stack-RAM bus of the RPN stack controller
interface rpn_stack_ctrl_if #(parameter int WIDTH = 8, parameter int ADDR_W = 5);
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [WIDTH-1:0]  cmd_data;
  logic              cmd_ready;
  logic              done;
  logic              err_overflow;
  logic              err_underflow;
  logic              err_illegal;
  logic [WIDTH-1:0]  tos;
  logic [ADDR_W:0]   depth;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  modport slave (
    input  cmd_valid, cmd, cmd_data, mem_rdata,
    output cmd_ready, done, err_overflow, err_underflow, err_illegal, tos, depth,
           mem_addr, mem_wr, mem_wdata
  );
  modport master (
    output cmd_valid, cmd, cmd_data, mem_rdata,
    input  cmd_ready, done, err_overflow, err_underflow, err_illegal, tos, depth,
           mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: RPN calculator stack sequencer with cached top-of-stack over a registered-read RAM
// Define RPN_MUL_EN to enable opcode 101 (MUL); otherwise it completes with err_illegal.
module rpn_stack_ctrl #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
) (
  input logic CLOCK_50,
  input logic reset,
  rpn_stack_ctrl_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);
  localparam logic [2:0] C_NOP = 3'd0, C_PUSH = 3'd1, C_POP = 3'd2, C_ADD = 3'd3,
                         C_SUB = 3'd4, C_MUL = 3'd5, C_DUP = 3'd6, C_CLEAR = 3'd7;
`ifdef RPN_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_EXEC, S_DONE} state_t;
  state_t state, state_nx;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q, tos_q, res;
  logic [ADDR_W:0]  depth_q;
  logic             ovf_q, unf_q, ill_q;
  logic             accept, binop, ovf, unf, ill, fail;
  // Error classification happens at accept time against the current depth.
  always_comb begin
    accept = state == S_IDLE && bus.cmd_valid;
    binop  = bus.cmd == C_ADD || bus.cmd == C_SUB || (bus.cmd == C_MUL && MUL_EN);
    ovf    = (bus.cmd == C_PUSH || bus.cmd == C_DUP) && depth_q == FULL;
    unf    = ((bus.cmd == C_POP || bus.cmd == C_DUP) && depth_q == '0) || (binop && depth_q < TWO);
    ill    = bus.cmd == C_MUL && !MUL_EN;
    fail   = ovf || unf || ill;
  end
  // mem_rdata here is the entry below the top (b); tos_q is a.
  always_comb begin
`ifdef RPN_MUL_EN
    res = op_q == C_ADD ? bus.mem_rdata + tos_q :
          op_q == C_SUB ? bus.mem_rdata - tos_q : WIDTH'(bus.mem_rdata * tos_q);
`else
    res = op_q == C_ADD ? bus.mem_rdata + tos_q : bus.mem_rdata - tos_q;
`endif
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept)
                 state_nx = (fail || bus.cmd == C_NOP || bus.cmd == C_CLEAR) ? S_DONE :
                            (bus.cmd == C_PUSH || bus.cmd == C_DUP) ? S_WRITE : S_READ;
      S_READ:  state_nx = op_q == C_POP ? S_DONE : S_EXEC;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      depth_q <= '0;
      tos_q   <= '0;
      op_q    <= C_NOP;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= bus.cmd;
        data_q <= bus.cmd_data;
        ovf_q  <= ovf;
        unf_q  <= unf;
        ill_q  <= ill;
      end
      if (state == S_WRITE) begin
        depth_q <= depth_q + ONE;
        tos_q   <= op_q == C_PUSH ? data_q : tos_q;
      end
      if (state == S_EXEC) begin
        depth_q <= depth_q - ONE;
        tos_q   <= res;
      end
      if (state == S_DONE && !(ovf_q || unf_q || ill_q) && op_q == C_POP) begin
        depth_q <= depth_q - ONE;
        tos_q   <= depth_q == ONE ? '0 : bus.mem_rdata;
      end
      if (state == S_DONE && !(ovf_q || unf_q || ill_q) && op_q == C_CLEAR) begin
        depth_q <= '0;
        tos_q   <= '0;
      end
    end
  end
  always_comb begin
    bus.cmd_ready     = state == S_IDLE;
    bus.done          = state == S_WRITE || state == S_EXEC || state == S_DONE;
    bus.err_overflow  = state == S_DONE && ovf_q;
    bus.err_underflow = state == S_DONE && unf_q;
    bus.err_illegal   = state == S_DONE && ill_q;
    bus.tos           = tos_q;
    bus.depth         = depth_q;
    bus.mem_wr        = state == S_WRITE || state == S_EXEC;
    bus.mem_addr      = state == S_WRITE ? depth_q[ADDR_W-1:0] :
                        (state == S_READ || state == S_EXEC) ? ADDR_W'(depth_q - TWO) : '0;
    bus.mem_wdata     = state == S_WRITE ? (op_q == C_PUSH ? data_q : tos_q) :
                        state == S_EXEC ? res : '0;
  end
endmodule
